uart_program_loader: RTL and testbench
======================================

Name: uart_program_loader

Overview:
- Upstream of the instruction memory. Receives a program image over the serial line `io_rx` (UART, 8N1) and writes it word by word into program memory.
- Raises `run_flag` once the complete image is stored, which releases fetch.
- Drives the program-memory write port (write enable, byte address, write data) that is currently tied off at the CPU top.

Parameters:
- CLKS_PER_BIT, 868, clock cycles per UART bit (100 MHz / 115200 baud); must be >= 4.
- MAX_WORDS, 1024, program memory capacity in 32-bit words; larger images are rejected.
- ADDR_W, 32, width of the byte address output.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- io_rx  in  1  asynchronous UART receive line, idle high
- mem_write_enable  out  1  one-cycle write strobe to program memory
- mem_address  out  ADDR_W  byte address of the word being written (word index * 4)
- mem_write_data  out  32  word to write
- loading  out  1  high from first accepted byte until DONE or ERROR
- run_flag  out  1  image complete; held until reset
- load_error  out  1  framing or length error; held until reset
- words_loaded  out  16  count of words written so far

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset (any state, including mid-frame or mid-word):
  - all outputs go to 0;
  - FSM returns to WAIT_LEN;
  - byte and word counters clear;
  - RX FSM returns to IDLE.
- RX front end:
  - `io_rx` passes through a 2-flop synchroniser, reset value 1.
  - IDLE: a falling edge on the synchronised line enters START.
  - START: wait CLKS_PER_BIT/2 cycles. If the line is still 0, go to DATA; otherwise it was a glitch, return to IDLE.
  - DATA: 8 samples, one every CLKS_PER_BIT cycles, LSB first.
  - STOP: sample after CLKS_PER_BIT cycles.
    - Stop bit = 1: pulse `byte_valid` for one cycle with the byte.
    - Stop bit = 0: pulse `frame_err` for one cycle; the byte is discarded.
  - After STOP, return to IDLE immediately so back-to-back frames are accepted.
- Loader FSM, states WAIT_LEN, LOAD, DONE, ERROR:
  - WAIT_LEN:
    - Collect 4 bytes, little-endian, into `len` (32 bits).
    - `loading` rises on the first byte.
    - On the 4th byte, `len == 0` or `len > MAX_WORDS` goes to ERROR; otherwise go to LOAD.
  - LOAD:
    - Assemble each word from 4 bytes, little-endian (first byte = bits 7:0).
    - On the cycle after the 4th byte's `byte_valid`, assert `mem_write_enable` for exactly one cycle.
    - In that cycle, `mem_address` = word_idx*4 and `mem_write_data` = the assembled word.
    - word_idx and `words_loaded` increment at the end of that cycle.
    - When word_idx reaches `len`, go to DONE in the same edge.
  - DONE:
    - `run_flag` = 1 and `loading` = 0.
    - Further bytes are ignored; no writes occur.
  - ERROR:
    - `load_error` = 1, `loading` = 0, `run_flag` = 0.
    - No writes occur; exit only by reset.
- `frame_err` in WAIT_LEN or LOAD goes to ERROR. A partial word is never written.
- `mem_address` and `mem_write_data` hold their last values when the strobe is low. `mem_write_enable` never asserts outside LOAD.
- `byte_valid` and the word-complete strobe cannot coincide, because a byte takes at least 10*CLKS_PER_BIT cycles.
- `words_loaded` saturates at 0xFFFF. It cannot wrap when MAX_WORDS <= 65535.
- Latency: from the mid-point of the last stop bit to `run_flag` is 2 cycles (write cycle, then DONE).

Decomposition:
- Shared package (common):
  - `loader_state_t` enum {WAIT_LEN, LOAD, DONE, ERROR};
  - `uart_rx_state_t` enum {IDLE, START, DATA, STOP};
  - constant `LOADER_BYTES_PER_WORD` = 4.
- One sub-module, `uart_rx`:
  - ports clk, reset, rx, byte_valid, byte_data[7:0], frame_err;
  - parameter CLKS_PER_BIT.
- The top holds the loader FSM, byte/word assembly and counters.

Test Plan (CLKS_PER_BIT=4, MAX_WORDS=16):
1. Reset, then send bytes 02 00 00 00, 13 05 10 00, 93 05 20 00 -> two writes:
   - addr 0x0, data 0x00100513;
   - addr 0x4, data 0x00200593;
   - each `mem_write_enable` exactly 1 cycle;
   - `words_loaded` = 2;
   - `run_flag` = 1 two cycles after the last stop-bit sample; `loading` = 0.
2. Send length 00 00 00 00 -> `load_error` = 1, no writes. Send length 11 00 00 00 (17 > 16) -> `load_error` = 1, no writes.
3. Length 1, then a byte whose stop bit is 0 -> `load_error` = 1, `mem_write_enable` never asserted, `run_flag` stays 0.
4. Drive `io_rx` low for 1 cycle (shorter than CLKS_PER_BIT/2), then send a valid image of length 1, data DEADBEEF little-endian -> glitch is ignored; single write of 0xDEADBEEF at addr 0.
5. Length 3; assert `reset` after the 2nd word, then send a full length-1 image -> after reset all outputs are 0; the new load writes to addr 0x0, `words_loaded` = 1, `run_flag` = 1.
6. After DONE, send 8 extra bytes -> no `mem_write_enable`; `run_flag` stays 1; `words_loaded` unchanged.

Source files
------------

// File: rtl/uart_program_loader_pkg.sv
// Shared types and constants for the UART program loader and its receiver.
package uart_program_loader_pkg;

  typedef enum logic [1:0] {
    WAIT_LEN,
    LOAD,
    DONE,
    ERROR
  } loader_state_t;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_rx_state_t;

  localparam int LOADER_BYTES_PER_WORD = 4;

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchroniser, mid-bit sampling, one-cycle byte/frame-error pulses.
module uart_rx
  import uart_program_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_err
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

  logic           sync1_q, sync1_d;
  logic           sync2_q, sync2_d;
  logic           prev_q, prev_d;
  uart_rx_state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]     bit_q, bit_d;
  logic [7:0]     shift_q, shift_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
    end
  end

  always_comb begin
    sync1_d    = rx;
    sync2_d    = sync1_q;
    prev_d     = sync2_q;
    state_d    = state_q;
    cnt_d      = cnt_q + 1'b1;
    bit_d      = bit_q;
    shift_d    = shift_q;
    byte_valid = 1'b0;
    frame_err  = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (prev_q && !sync2_q) state_d = START;
      end
      START: begin
        // A line that is high again at mid start bit was only a glitch.
        if (cnt_q == HALF_LAST) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = sync2_q ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          shift_d = {sync2_q, shift_q[7:1]};
          bit_d   = bit_q + 1'b1;
          if (bit_q == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d      = '0;
          state_d    = IDLE;
          byte_valid = sync2_q;
          frame_err  = !sync2_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign byte_data = shift_q;

endmodule

// File: rtl/uart_program_loader.sv
// Receives a length-prefixed little-endian program image over UART and writes it to program memory.
module uart_program_loader
  import uart_program_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int MAX_WORDS    = 1024,
  parameter int ADDR_W       = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              io_rx,
  output logic              mem_write_enable,
  output logic [ADDR_W-1:0] mem_address,
  output logic [31:0]       mem_write_data,
  output logic              loading,
  output logic              run_flag,
  output logic              load_error,
  output logic [15:0]       words_loaded,
  output loader_state_t     dbg_loader_state
);

  localparam logic [1:0] LAST_BYTE = 2'(LOADER_BYTES_PER_WORD - 1);

  logic       rx_valid;
  logic [7:0] rx_byte;
  logic       rx_frame_err;

  uart_rx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_uart_rx (
    .clk       (clk),
    .reset     (reset),
    .rx        (io_rx),
    .byte_valid(rx_valid),
    .byte_data (rx_byte),
    .frame_err (rx_frame_err)
  );

  loader_state_t     state_q, state_d;
  logic [1:0]        byte_cnt_q, byte_cnt_d;
  logic [31:0]       len_q, len_d;
  logic [31:0]       word_q, word_d;
  logic [31:0]       word_idx_q, word_idx_d;
  logic              wen_q, wen_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       data_q, data_d;
  logic [15:0]       words_q, words_d;
  logic              loading_q, loading_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= WAIT_LEN;
      byte_cnt_q <= '0;
      len_q      <= '0;
      word_q     <= '0;
      word_idx_q <= '0;
      wen_q      <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      words_q    <= '0;
      loading_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      len_q      <= len_d;
      word_q     <= word_d;
      word_idx_q <= word_idx_d;
      wen_q      <= wen_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      words_q    <= words_d;
      loading_q  <= loading_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    len_d      = len_q;
    word_d     = word_q;
    word_idx_d = word_idx_q;
    wen_d      = 1'b0;
    addr_d     = addr_q;
    data_d     = data_q;
    words_d    = words_q;
    loading_d  = loading_q;
    case (state_q)
      WAIT_LEN: begin
        if (rx_frame_err) begin
          state_d   = ERROR;
          loading_d = 1'b0;
        end else if (rx_valid) begin
          loading_d  = 1'b1;
          len_d      = {rx_byte, len_q[31:8]};
          byte_cnt_d = byte_cnt_q + 1'b1;
          if (byte_cnt_q == LAST_BYTE) begin
            if (len_d == 32'd0 || len_d > 32'(MAX_WORDS)) begin
              state_d   = ERROR;
              loading_d = 1'b0;
            end else begin
              state_d = LOAD;
            end
          end
        end
      end
      LOAD: begin
        if (rx_frame_err) begin
          state_d   = ERROR;
          loading_d = 1'b0;
        end else if (rx_valid) begin
          word_d     = {rx_byte, word_q[31:8]};
          byte_cnt_d = byte_cnt_q + 1'b1;
          if (byte_cnt_q == LAST_BYTE) begin
            wen_d  = 1'b1;
            data_d = word_d;
            addr_d = ADDR_W'(word_idx_q) << 2;
          end
        end
        // Counters advance at the end of the write cycle; the final word ends the load.
        if (wen_q) begin
          word_idx_d = word_idx_q + 32'd1;
          words_d    = (words_q == 16'hFFFF) ? words_q : words_q + 16'd1;
          if (word_idx_d == len_q) begin
            state_d   = DONE;
            loading_d = 1'b0;
          end
        end
      end
      DONE:    ;
      ERROR:   ;
      default: state_d = ERROR;
    endcase
  end

  assign mem_write_enable = wen_q;
  assign mem_address      = addr_q;
  assign mem_write_data   = data_q;
  assign loading          = loading_q;
  assign run_flag         = (state_q == DONE);
  assign load_error       = (state_q == ERROR);
  assign words_loaded     = words_q;
  assign dbg_loader_state = state_q;

endmodule

// File: tb/tb_uart_program_loader.sv
// Self-checking bench for uart_program_loader: table vectors, hand sequences, randomized images vs. a model.
module tb_uart_program_loader;
  import uart_program_loader_pkg::*;

  localparam int CPB = 4;
  localparam int MW  = 16;
  localparam int AW  = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          io_rx = 1'b1;
  logic          mem_write_enable;
  logic [AW-1:0] mem_address;
  logic [31:0]   mem_write_data;
  logic          loading;
  logic          run_flag;
  logic          load_error;
  logic [15:0]   words_loaded;
  loader_state_t dbg_state;

  uart_program_loader #(
    .CLKS_PER_BIT(CPB),
    .MAX_WORDS   (MW),
    .ADDR_W      (AW)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .io_rx           (io_rx),
    .mem_write_enable(mem_write_enable),
    .mem_address     (mem_address),
    .mem_write_data  (mem_write_data),
    .loading         (loading),
    .run_flag        (run_flag),
    .load_error      (load_error),
    .words_loaded    (words_loaded),
    .dbg_loader_state(dbg_state)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  logic [63:0] exp_q[$];
  logic [63:0] got_q[$];
  logic wen_prev = 1'b0;

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Write monitor: records every strobe and requires it to be one cycle wide.
  always @(negedge clk) begin
    if (mem_write_enable) begin
      got_q.push_back({mem_address, mem_write_data});
      check("wen_single_cycle", 96'(wen_prev), 96'd0);
    end
    wen_prev <= mem_write_enable;
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    io_rx = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_outputs",
          96'({mem_write_enable, loading, run_flag, load_error, words_loaded}), 96'd0);
    check("reset_addr_data", 96'({mem_address, mem_write_data}), 96'd0);
    reset = 1'b0;
    exp_q.delete();
    got_q.delete();
    repeat (2) @(negedge clk);
  endtask

  // Called at a negedge; returns at the negedge just before the stop-bit sample edge.
  task automatic send_byte(input logic [7:0] b, input bit stop_ok);
    io_rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      io_rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    io_rx = stop_ok;
    repeat (CPB) @(negedge clk);
    if (!stop_ok) begin
      io_rx = 1'b1;
      repeat (CPB) @(negedge clk);
    end
  endtask

  task automatic compare_writes(input string tag);
    int n;
    check({tag, "_write_count"}, 96'(got_q.size()), 96'(exp_q.size()));
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check({tag, "_write"}, 96'(got_q[i]), 96'(exp_q[i]));
    exp_q.delete();
    got_q.delete();
  endtask

  task automatic check_final(input string tag, input bit run, input bit err, input int words);
    check({tag, "_run_flag"}, 96'(run_flag), 96'(run));
    check({tag, "_load_error"}, 96'(load_error), 96'(err));
    check({tag, "_loading"}, 96'(loading), 96'd0);
    check({tag, "_words"}, 96'(words_loaded), 96'(words));
  endtask

  // Reference: len is the first 4 bytes little-endian; each following group of 4 bytes
  // is one word at byte address 4*index; a bad stop bit before completion aborts.
  task automatic model(input logic [7:0] bq[$], input int bad,
                       output bit run, output bit err, output int words);
    logic [31:0] len;
    run = 1'b0;
    err = 1'b0;
    words = 0;
    if (bad >= 0 && bad < 4) begin
      err = 1'b1;
      return;
    end
    len = {bq[3], bq[2], bq[1], bq[0]};
    if (len == 0 || len > MW) begin
      err = 1'b1;
      return;
    end
    for (int wi = 0; wi < int'(len); wi++) begin
      int base;
      base = 4 + 4 * wi;
      if (bad >= base && bad < base + 4) begin
        err = 1'b1;
        return;
      end
      if (bq.size() < base + 4) return;
      exp_q.push_back({32'(wi * 4), bq[base + 3], bq[base + 2], bq[base + 1], bq[base]});
      words++;
    end
    run = 1'b1;
  endtask

  typedef struct {
    string        name;
    int           n;
    logic [127:0] bytes;
    int           bad;
    bit           glitch;
    bit           exp_run;
    bit           exp_err;
    int           exp_words;
    logic [31:0]  d0;
    logic [31:0]  d1;
  } vec_t;

  vec_t vecs[5];

  initial begin
    logic [7:0] bq[$];
    bit m_run, m_err;
    int m_words, len, nw, bad, r;

    vecs[0] = '{"two_words", 12, 128'h002005930010051300000002, -1, 1'b0, 1'b1, 1'b0, 2,
                32'h00100513, 32'h00200593};
    vecs[1] = '{"len_zero", 4, 128'h00000000, -1, 1'b0, 1'b0, 1'b1, 0, 32'h0, 32'h0};
    vecs[2] = '{"len_too_big", 4, 128'h00000011, -1, 1'b0, 1'b0, 1'b1, 0, 32'h0, 32'h0};
    vecs[3] = '{"bad_stop", 5, 128'hAA00000001, 4, 1'b0, 1'b0, 1'b1, 0, 32'h0, 32'h0};
    vecs[4] = '{"glitch", 8, 128'hDEADBEEF00000001, -1, 1'b1, 1'b1, 1'b0, 1,
                32'hDEADBEEF, 32'h0};

    for (int v = 0; v < 5; v++) begin
      do_reset();
      if (vecs[v].exp_words > 0) exp_q.push_back({32'h0, vecs[v].d0});
      if (vecs[v].exp_words > 1) exp_q.push_back({32'h4, vecs[v].d1});
      if (vecs[v].glitch) begin
        io_rx = 1'b0;
        @(negedge clk);
        io_rx = 1'b1;
        repeat (10) @(negedge clk);
      end
      for (int i = 0; i < vecs[v].n; i++) begin
        send_byte(vecs[v].bytes[8*i +: 8], i != vecs[v].bad);
        if (vecs[v].exp_run && i >= 1 && i < vecs[v].n - 1)
          check({vecs[v].name, "_loading_mid"}, 96'(loading), 96'd1);
      end
      io_rx = 1'b1;
      if (vecs[v].exp_run) begin
        @(negedge clk);
        check({vecs[v].name, "_wen_after_stop"}, 96'(mem_write_enable), 96'd1);
        check({vecs[v].name, "_run_not_yet"}, 96'(run_flag), 96'd0);
        @(negedge clk);
        check({vecs[v].name, "_run_latency"}, 96'(run_flag), 96'd1);
      end
      repeat (4) @(negedge clk);
      check_final(vecs[v].name, vecs[v].exp_run, vecs[v].exp_err, vecs[v].exp_words);
      compare_writes(vecs[v].name);
    end

    // Reset in the middle of a length-3 load, then a fresh length-1 image.
    do_reset();
    bq = '{8'h03, 8'h00, 8'h00, 8'h00};
    for (int i = 0; i < 8; i++) bq.push_back(8'($urandom_range(0, 255)));
    exp_q.push_back({32'h0, bq[7], bq[6], bq[5], bq[4]});
    exp_q.push_back({32'h4, bq[11], bq[10], bq[9], bq[8]});
    foreach (bq[i]) send_byte(bq[i], 1'b1);
    io_rx = 1'b1;
    repeat (3) @(negedge clk);
    check("midload_words", 96'(words_loaded), 96'd2);
    check("midload_loading", 96'(loading), 96'd1);
    compare_writes("midload");
    do_reset();
    exp_q.push_back({32'h0, 32'h12345678});
    bq = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12};
    foreach (bq[i]) send_byte(bq[i], 1'b1);
    io_rx = 1'b1;
    repeat (4) @(negedge clk);
    check_final("after_reset", 1'b1, 1'b0, 1);
    compare_writes("after_reset");

    // Bytes after DONE must be ignored.
    for (int i = 0; i < 8; i++) send_byte(8'($urandom_range(0, 255)), 1'b1);
    io_rx = 1'b1;
    repeat (4) @(negedge clk);
    check_final("post_done", 1'b1, 1'b0, 1);
    compare_writes("post_done");

    // Randomized images, including boundary lengths, checked against the model.
    for (int it = 0; it < 8; it++) begin
      do_reset();
      bq.delete();
      r = $urandom_range(0, 9);
      if (r == 0) len = 0;
      else if (r == 1) len = MW + $urandom_range(1, 3);
      else if (r == 2) len = MW;
      else len = $urandom_range(1, 4);
      for (int k = 0; k < 4; k++) bq.push_back(8'(len >> (8 * k)));
      nw = (len >= 1 && len <= MW) ? len : 0;
      for (int k = 0; k < 4 * nw + $urandom_range(0, 2); k++)
        bq.push_back(8'($urandom_range(0, 255)));
      bad = ($urandom_range(0, 3) == 0) ? $urandom_range(0, bq.size() - 1) : -1;
      model(bq, bad, m_run, m_err, m_words);
      foreach (bq[i]) send_byte(bq[i], i != bad);
      io_rx = 1'b1;
      repeat (4) @(negedge clk);
      check_final("random", m_run, m_err, m_words);
      compare_writes("random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
